// File: rtl/gemm_pkg.sv
// rtl/gemm_pkg.sv - shared types and saturation bounds for the tiled GEMM array
package gemm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FLUSH,
    ST_DRAIN,
    ST_DONE
  } gemm_state_e;

  // Largest positive value representable in a signed field of the given width
  function automatic logic signed [63:0] SAT_MAX(input int width);
    return (64'sd1 <<< (width - 1)) - 64'sd1;
  endfunction

  // Most negative value representable in a signed field of the given width
  function automatic logic signed [63:0] SAT_MIN(input int width);
    return -(64'sd1 <<< (width - 1));
  endfunction

endpackage

// File: rtl/gemm_mac_pe.sv
// rtl/gemm_mac_pe.sv - one signed MAC cell; GEMM_TILE_SATURATE_EN selects sticky saturation
module gemm_mac_pe
  import gemm_pkg::*;
#(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           clr_i,
  input  logic                           en_i,
  input  logic signed [InDataWidth-1:0]  a_i,
  input  logic signed [InDataWidth-1:0]  b_i,
  output logic signed [OutDataWidth-1:0] acc_o
);

  localparam int ProdWidth = 2 * InDataWidth;

  logic signed [ProdWidth-1:0]    prod;
  logic signed [OutDataWidth-1:0] prod_ext;
  logic signed [OutDataWidth-1:0] base;
  logic signed [OutDataWidth-1:0] acc_next;

  assign prod     = ProdWidth'(a_i) * ProdWidth'(b_i);
  assign prod_ext = OutDataWidth'(prod);
  // The first product of a tile replaces the old sum instead of adding to it
  assign base     = clr_i ? '0 : acc_o;

`ifdef GEMM_TILE_SATURATE_EN
  logic signed [OutDataWidth:0] wide;
  logic                         sat_hit;
  logic                         sat_q;

  // One extra bit exposes overflow; clamp to the signed range when it happens
  always_comb begin
    wide     = (OutDataWidth + 1)'(base) + (OutDataWidth + 1)'(prod_ext);
    sat_hit  = (wide[OutDataWidth] != wide[OutDataWidth-1]);
    acc_next = wide[OutDataWidth-1:0];
    if (sat_hit) begin
      acc_next = wide[OutDataWidth] ? OutDataWidth'(SAT_MIN(OutDataWidth))
                                    : OutDataWidth'(SAT_MAX(OutDataWidth));
    end
  end

  // Once clamped, the cell holds its bound until the next tile clears it
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_o <= '0;
      sat_q <= 1'b0;
    end else if (en_i && (clr_i || !sat_q)) begin
      acc_o <= acc_next;
      sat_q <= sat_hit;
    end
  end
`else
  // Plain two's-complement accumulation wraps naturally at the register width
  always_comb begin
    acc_next = base + prod_ext;
  end

  // Accumulate whenever the sequencer marks the incoming SRAM data as valid
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_o <= '0;
    end else if (en_i) begin
      acc_o <= acc_next;
    end
  end
`endif

endmodule

// File: rtl/gemm_tile_array.sv
// rtl/gemm_tile_array.sv - output-stationary TileM x TileN GEMM with address sequencer; option GEMM_TILE_SATURATE_EN
module gemm_tile_array
  import gemm_pkg::*;
#(
  parameter int InDataWidth  = 8,
  parameter int OutDataWidth = 32,
  parameter int TileM        = 4,
  parameter int TileN        = 4,
  parameter int AddrWidth    = 12,
  parameter int SizeWidth    = 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            start_i,
  input  logic [SizeWidth-1:0]            M_i,
  input  logic [SizeWidth-1:0]            K_i,
  input  logic [SizeWidth-1:0]            N_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic                            err_o,
  output logic [AddrWidth-1:0]            a_addr_o,
  input  logic [InDataWidth*TileM-1:0]    a_rdata_i,
  output logic [AddrWidth-1:0]            b_addr_o,
  input  logic [InDataWidth*TileN-1:0]    b_rdata_i,
  output logic [AddrWidth-1:0]            c_addr_o,
  output logic [OutDataWidth*TileN-1:0]   c_wdata_o,
  output logic                            c_we_o
);

  localparam int IdxW = (TileM > 1) ? $clog2(TileM) : 1;
  localparam logic [SizeWidth-1:0] One     = SizeWidth'(1);
  localparam logic [IdxW-1:0]      LastRow = IdxW'(TileM - 1);

  gemm_state_e          state_q;
  logic [SizeWidth-1:0] k_len;
  logic [SizeWidth-1:0] m_tiles;
  logic [SizeWidth-1:0] n_tiles;
  logic [SizeWidth-1:0] k_cnt;
  logic [SizeWidth-1:0] mt_cnt;
  logic [SizeWidth-1:0] nt_cnt;
  logic [IdxW-1:0]      i_cnt;
  logic                 err_q;
  logic                 mac_en_q;
  logic                 mac_clr_q;

  logic                 size_bad;
  logic                 nt_last;
  logic                 mt_last;
  logic [SizeWidth-1:0] nt_next;
  logic [SizeWidth-1:0] mt_next;

  logic [OutDataWidth-1:0] acc [TileM][TileN];

  function automatic logic [AddrWidth-1:0] a_addr_f(input logic [SizeWidth-1:0] mt,
                                                    input logic [SizeWidth-1:0] kl,
                                                    input logic [SizeWidth-1:0] k);
    return AddrWidth'(32'(mt) * 32'(kl) + 32'(k));
  endfunction

  function automatic logic [AddrWidth-1:0] b_addr_f(input logic [SizeWidth-1:0] k,
                                                    input logic [SizeWidth-1:0] ntl,
                                                    input logic [SizeWidth-1:0] nt);
    return AddrWidth'(32'(k) * 32'(ntl) + 32'(nt));
  endfunction

  function automatic logic [AddrWidth-1:0] c_addr_f(input logic [SizeWidth-1:0] mt,
                                                    input logic [IdxW-1:0]      i,
                                                    input logic [SizeWidth-1:0] nt,
                                                    input logic [SizeWidth-1:0] ntl);
    return AddrWidth'((32'(mt) * 32'(TileM) + 32'(i)) * 32'(ntl) + 32'(nt));
  endfunction

  // Size legality and next-tile position (nt inner loop, mt outer loop)
  always_comb begin
    size_bad = (M_i == '0) || (K_i == '0) || (N_i == '0) ||
               ((M_i % SizeWidth'(TileM)) != '0) ||
               ((N_i % SizeWidth'(TileN)) != '0);
    nt_last  = (nt_cnt == n_tiles - One);
    mt_last  = (mt_cnt == m_tiles - One);
    nt_next  = nt_last ? '0 : nt_cnt + One;
    mt_next  = nt_last ? mt_cnt + One : mt_cnt;
  end

  // Sequencer: drives SRAM addresses, MAC enables one cycle behind, and drains rows
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      k_len     <= '0;
      m_tiles   <= '0;
      n_tiles   <= '0;
      k_cnt     <= '0;
      mt_cnt    <= '0;
      nt_cnt    <= '0;
      i_cnt     <= '0;
      err_q     <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      c_we_o    <= 1'b0;
      a_addr_o  <= '0;
      b_addr_o  <= '0;
      c_addr_o  <= '0;
    end else begin
      done_o    <= 1'b0;
      err_o     <= 1'b0;
      c_we_o    <= 1'b0;
      mac_en_q  <= 1'b0;
      mac_clr_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            k_len    <= K_i;
            m_tiles  <= M_i / SizeWidth'(TileM);
            n_tiles  <= N_i / SizeWidth'(TileN);
            err_q    <= size_bad;
            k_cnt    <= '0;
            mt_cnt   <= '0;
            nt_cnt   <= '0;
            a_addr_o <= '0;
            b_addr_o <= '0;
            busy_o   <= 1'b1;
            state_q  <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (err_q) begin
            busy_o  <= 1'b0;
            done_o  <= 1'b1;
            err_o   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            mac_en_q  <= 1'b1;
            mac_clr_q <= (k_cnt == '0);
            if (k_cnt == k_len - One) begin
              state_q <= ST_FLUSH;
            end else begin
              k_cnt    <= k_cnt + One;
              a_addr_o <= a_addr_f(mt_cnt, k_len, k_cnt + One);
              b_addr_o <= b_addr_f(k_cnt + One, n_tiles, nt_cnt);
            end
          end
        end
        ST_FLUSH: begin
          i_cnt    <= '0;
          c_we_o   <= 1'b1;
          c_addr_o <= c_addr_f(mt_cnt, '0, nt_cnt, n_tiles);
          state_q  <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (i_cnt == LastRow) begin
            if (nt_last && mt_last) begin
              busy_o  <= 1'b0;
              done_o  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              nt_cnt   <= nt_next;
              mt_cnt   <= mt_next;
              k_cnt    <= '0;
              a_addr_o <= a_addr_f(mt_next, k_len, '0);
              b_addr_o <= b_addr_f('0, n_tiles, nt_next);
              state_q  <= ST_FETCH;
            end
          end else begin
            i_cnt    <= i_cnt + IdxW'(1);
            c_we_o   <= 1'b1;
            c_addr_o <= c_addr_f(mt_cnt, i_cnt + IdxW'(1), nt_cnt, n_tiles);
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  for (genvar gi = 0; gi < TileM; gi++) begin : g_row
    for (genvar gj = 0; gj < TileN; gj++) begin : g_col
      gemm_mac_pe #(
        .InDataWidth (InDataWidth),
        .OutDataWidth(OutDataWidth)
      ) u_pe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .clr_i (mac_clr_q),
        .en_i  (mac_en_q),
        .a_i   (a_rdata_i[gi*InDataWidth +: InDataWidth]),
        .b_i   (b_rdata_i[gj*InDataWidth +: InDataWidth]),
        .acc_o (acc[gi][gj])
      );
    end
  end

  // C row mux: the accumulator row selected by the drain row counter
  always_comb begin
    c_wdata_o = '0;
    for (int j = 0; j < TileN; j++) begin
      c_wdata_o[j*OutDataWidth +: OutDataWidth] = acc[i_cnt][j];
    end
  end

endmodule

// File: tb/tb_gemm_tile_array.sv
// tb/tb_gemm_tile_array.sv - self-checking bench for gemm_tile_array (16-bit accumulators)
module tb_gemm_tile_array;

  logic        clk;
  logic        rst_ni;
  logic        start_i;
  logic [7:0]  M_i, K_i, N_i;
  logic        busy_o, done_o, err_o;
  logic [11:0] a_addr_o, b_addr_o, c_addr_o;
  logic [31:0] a_rdata_i, b_rdata_i;
  logic [63:0] c_wdata_o;
  logic        c_we_o;

  gemm_tile_array #(
    .InDataWidth(8), .OutDataWidth(16), .TileM(4), .TileN(4), .AddrWidth(12), .SizeWidth(8)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni), .start_i(start_i),
    .M_i(M_i), .K_i(K_i), .N_i(N_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .a_addr_o(a_addr_o), .a_rdata_i(a_rdata_i),
    .b_addr_o(b_addr_o), .b_rdata_i(b_rdata_i),
    .c_addr_o(c_addr_o), .c_wdata_o(c_wdata_o), .c_we_o(c_we_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] a_mem [0:4095];
  logic [31:0] b_mem [0:4095];
  logic [63:0] c_cap [0:4095];
  int          a_mat [0:31][0:254];
  int          b_mat [0:254][0:31];
  logic [15:0] exp_c [0:31][0:31];

  int n_checks = 0;
  int n_fail   = 0;

  bit active = 0;
  bit done_seen;
  int run_cyc, done_cyc, writes;
  int cur_k, cur_ntl, exp_d;
  bit cur_ill;

  always @(posedge clk) begin
    a_rdata_i <= a_mem[a_addr_o];
    b_rdata_i <= b_mem[b_addr_o];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (run cycle %0d)", name, act, exp, run_cyc);
    end
  endtask

  function automatic logic [63:0] exp_row(input int r, input int nt);
    logic [63:0] w;
    for (int j = 0; j < 4; j++) w[j*16 +: 16] = exp_c[r][nt*4+j];
    return w;
  endfunction

  // Compare process: every cycle of a run, outputs follow the tile schedule and golden C
  always @(negedge clk) begin : cmp
    int  t, per, pos, p, mt, nt, row;
    bit  e_busy, e_done, e_we;
    if (active) begin
      t      = run_cyc;
      per    = cur_k + 1 + 4;
      e_busy = (t >= 1) && (t < exp_d);
      e_done = (t == exp_d);
      e_we   = 1'b0;
      pos    = 0;
      if (!cur_ill && e_busy) begin
        pos  = (t - 1) % per;
        e_we = (pos >= cur_k + 1);
      end
      chk("busy", busy_o, e_busy);
      chk("done", done_o, e_done);
      chk("err", err_o, e_done && cur_ill);
      chk("c_we", c_we_o, e_we);
      if (e_we && c_we_o) begin
        p   = (t - 1) / per;
        mt  = p / cur_ntl;
        nt  = p % cur_ntl;
        row = mt * 4 + pos - (cur_k + 1);
        chk("c_addr", c_addr_o, row * cur_ntl + nt);
        chk("c_wdata", c_wdata_o, exp_row(row, nt));
      end
      if (c_we_o) begin
        c_cap[c_addr_o] = c_wdata_o;
        writes++;
      end
      if (done_o) begin
        done_seen = 1'b1;
        done_cyc  = t;
      end
      run_cyc++;
    end
  end

  // pat: 0 identity, 1 random signed, 2 all -128
  task automatic setup_and_start(input int m, input int k, input int n, input int pat);
    longint acc;
    bit     sat;
    int     ntl;
    cur_ill = (m == 0) || (k == 0) || (n == 0) || (m % 4 != 0) || (n % 4 != 0);
    ntl     = cur_ill ? 1 : n / 4;
    if (!cur_ill) begin
      for (int r = 0; r < m; r++)
        for (int kk = 0; kk < k; kk++)
          a_mat[r][kk] = (pat == 0) ? ((r == kk) ? 1 : 0) :
                         (pat == 1) ? (int'($urandom_range(0, 255)) - 128) : -128;
      for (int kk = 0; kk < k; kk++)
        for (int c = 0; c < n; c++)
          b_mat[kk][c] = (pat == 0) ? ((kk == c) ? 1 : 0) :
                         (pat == 1) ? (int'($urandom_range(0, 255)) - 128) : -128;
      for (int mt = 0; mt < m / 4; mt++)
        for (int kk = 0; kk < k; kk++)
          for (int i = 0; i < 4; i++)
            a_mem[mt*k+kk][i*8 +: 8] = 8'(a_mat[mt*4+i][kk]);
      for (int kk = 0; kk < k; kk++)
        for (int nt = 0; nt < ntl; nt++)
          for (int j = 0; j < 4; j++)
            b_mem[kk*ntl+nt][j*8 +: 8] = 8'(b_mat[kk][nt*4+j]);
      for (int r = 0; r < m; r++)
        for (int c = 0; c < n; c++) begin
          acc = 0;
          sat = 1'b0;
          for (int kk = 0; kk < k; kk++) begin
            if (!sat) acc += longint'(a_mat[r][kk]) * longint'(b_mat[kk][c]);
`ifdef GEMM_TILE_SATURATE_EN
            if (acc > 32767) begin acc = 32767; sat = 1'b1; end
            else if (acc < -32768) begin acc = -32768; sat = 1'b1; end
`endif
          end
          exp_c[r][c] = 16'(acc);
        end
    end
    cur_k   = k;
    cur_ntl = ntl;
    exp_d   = cur_ill ? 2 : (m / 4) * ntl * (k + 5) + 1;
    @(posedge clk); #1;
    M_i = 8'(m); K_i = 8'(k); N_i = 8'(n);
    start_i   = 1'b1;
    run_cyc   = 0;
    writes    = 0;
    done_seen = 1'b0;
    active    = 1'b1;
    @(posedge clk); #1;
    start_i = 1'b0;
  endtask

  task automatic run_gemm(input int m, input int k, input int n, input int pat, input bit poke);
    setup_and_start(m, k, n, pat);
    for (int c = 0; c < 30000 && !done_seen; c++) begin
      if (poke && c == 3) begin
        start_i = 1'b1; M_i = 8'd8; K_i = 8'd3; N_i = 8'd8;
      end else begin
        start_i = 1'b0;
      end
      @(posedge clk); #1;
    end
    start_i = 1'b0;
    chk("done_within_budget", done_seen, 1'b1);
    @(posedge clk); #1;
    active = 1'b0;
    chk("write_count", writes, cur_ill ? 0 : m * n / 4);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, busy_o, 0);
    chk({tag, "_done"}, done_o, 0);
    chk({tag, "_err"}, err_o, 0);
    chk({tag, "_c_we"}, c_we_o, 0);
    chk({tag, "_a_addr"}, a_addr_o, 0);
    chk({tag, "_b_addr"}, b_addr_o, 0);
    chk({tag, "_c_addr"}, c_addr_o, 0);
    chk({tag, "_c_wdata"}, c_wdata_o, 0);
  endtask

  initial begin
    rst_ni  = 1'b0;
    start_i = 1'b0;
    M_i = '0; K_i = '0; N_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst_ni = 1'b1;

    // identity: C = I, done at cycle 10, four row writes
    run_gemm(4, 4, 4, 0, 1'b0);
    chk("ident_done_cycle", done_cyc, 10);
    chk("ident_row0", c_cap[0], 64'h0000_0000_0000_0001);
    chk("ident_row2", c_cap[2], 64'h0000_0001_0000_0000);
    chk("ident_row3", c_cap[3], 64'h0001_0000_0000_0000);

    // illegal sizes: done+err two cycles after start, no writes
    run_gemm(6, 4, 4, 1, 1'b0);
    chk("ill_m_done_cycle", done_cyc, 2);
    run_gemm(4, 0, 4, 1, 1'b0);
    chk("ill_k_done_cycle", done_cyc, 2);
    run_gemm(4, 4, 6, 1, 1'b0);

    // overflow of 16-bit accumulators: 255 * 16384
    run_gemm(4, 255, 4, 2, 1'b0);
`ifdef GEMM_TILE_SATURATE_EN
    chk("ovf_row0", c_cap[0], 64'h7FFF_7FFF_7FFF_7FFF);
    chk("ovf_row3", c_cap[3], 64'h7FFF_7FFF_7FFF_7FFF);
`else
    chk("ovf_row0", c_cap[0], 64'hC000_C000_C000_C000);
    chk("ovf_row3", c_cap[3], 64'hC000_C000_C000_C000);
`endif

    // random runs; run 0 also pulses start_i while busy
    for (int r = 0; r < 20; r++) begin
      run_gemm(4 * int'($urandom_range(1, 8)), int'($urandom_range(1, 32)),
               4 * int'($urandom_range(1, 8)), 1, (r == 0));
    end

    // mid-run reset held 3 cycles
    setup_and_start(8, 8, 8, 1);
    repeat (20) @(posedge clk);
    #1;
    active = 1'b0;
    rst_ni = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("midrst");
    end
    rst_ni = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk("post_rst_c_we", c_we_o, 0);
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_done", done_o, 0);
    end
    run_gemm(4, 4, 4, 0, 1'b0);
    chk("post_rst_done_cycle", done_cyc, 10);
    chk("post_rst_row1", c_cap[1], 64'h0000_0000_0001_0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
